aes_cipher_core: RTL and testbench

Iterative AES-128 forward cipher: accepts one 128-bit plaintext block, applies the initial AddRoundKey, then one full round per clock (SubBytes, ShiftRows, MixColumns, AddRoundKey; MixColumns omitted in the final round), and presents the ciphertext. It is the encryption counterpart of the decrypt datapath. It obtains round keys from the shared external key-expansion store through an index/key lookup port and sits between the block-input FIFO and the output stage.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_cipher_core_if.sv | 27 ++
 rtl/aes_cipher_core_shift_rows.sv | 17 +
 rtl/aes_cipher_core.sv | 102 ++++++++++
 tb/tb_aes_cipher_core.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: block sizes, state and FSM types, the forward
// S-box and the MixColumns column helper.
package aes_pkg;

    localparam int NR_128  = 10;
    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    // Forward S-box; entry 0 sits in the top byte, entry 255 in the bottom byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b starts at bit 8*(255-b); {~b, 3'b000} is that offset.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; row 0 is the most significant byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// Block handshake and round-key lookup bundle for the AES cipher core.
// master is the surrounding system (input FIFO, key store, output stage);
// slave is the core itself.
interface aes_cipher_core_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    state_t     plaintext;
    logic [3:0] rk_idx;
    state_t     rk;
    logic       out_valid;
    logic       out_ready;
    state_t     ciphertext;
    logic       busy;

    modport master (
        output in_valid, plaintext, rk, out_ready,
        input  in_ready, rk_idx, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, rk, out_ready,
        output in_ready, rk_idx, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/aes_cipher_core_shift_rows.sv
// Forward AES ShiftRows: purely combinational byte permutation.
// Row r of the state is rotated left by r byte positions, so new column c
// of row r takes old column (c + r) mod 4.
module shift_rows
    import aes_pkg::*;
(
    input  state_t blk,
    output state_t shifted
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127-32*c-8*r -: 8] = blk[127-32*((c+r)%4)-8*r -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: initial AddRoundKey on accept, then one
// full round per clock, ciphertext held in a register until downstream takes it.
// Round keys come from an external store addressed by rk_idx, which is decoded
// from registered state only so the store has a whole cycle to answer.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NR = NR_128    // only 10 (AES-128) is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_cipher_core_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_t       fsm, fsm_next;
    state_t     st, st_next;
    state_t     ct, ct_next;
    logic [3:0] rnd, rnd_next;
    logic [3:0] rk_idx;

    state_t     subbed;
    state_t     shifted;
    state_t     mixed;
    state_t     round_out;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        assign subbed[8*i +: 8] = sbox(st[8*i +: 8]);
    end

    shift_rows u_shift_rows (
        .blk     (subbed),
        .shifted (shifted)
    );

    for (genvar c = 0; c < 4; c++) begin : g_mix_columns
        assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end

    assign round_out = (rnd == LAST_RND) ? shifted : mixed;

    // State, round counter and ciphertext registers; reset discards any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            st  <= '0;
            rnd <= '0;
            ct  <= '0;
        end else begin
            fsm <= fsm_next;
            st  <= st_next;
            rnd <= rnd_next;
            ct  <= ct_next;
        end
    end

    // Next-state, round datapath selection and round-key index decode
    always_comb begin
        fsm_next = fsm;
        st_next  = st;
        rnd_next = rnd;
        ct_next  = ct;
        rk_idx   = 4'd0;
        case (fsm)
            IDLE: begin
                if (bus.in_valid) begin
                    st_next  = bus.plaintext ^ bus.rk;
                    rnd_next = 4'd1;
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = rnd;
                st_next = round_out ^ bus.rk;
                if (rnd == LAST_RND) begin
                    ct_next  = round_out ^ bus.rk;
                    rnd_next = 4'd0;
                    fsm_next = DONE;
                end else begin
                    rnd_next = rnd + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ct_next  = '0;
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = (fsm == IDLE);
    assign bus.out_valid  = (fsm == DONE);
    assign bus.busy       = (fsm != IDLE);
    assign bus.ciphertext = ct;
    assign bus.rk_idx     = rk_idx;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: a key store built from its own
// key expansion, directed known-answer blocks, and a scoreboard monitor that
// pops expected ciphertexts whenever the core hands a block downstream.
module tb_aes_cipher_core;
    import aes_pkg::*;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst_n;
    logic key_sel;
    int   cycle;
    int   checks;
    int   failures;
    int   accepts;
    int   last_acc_edge;
    logic prev_ov;

    logic [7:0]   tb_sbox [256];
    logic [127:0] rk_tab [2][11];
    logic [127:0] exp_q [$];
    logic [127:0] kat_pt [5];
    logic [127:0] kat_ct [5];

    aes_cipher_core_if bus ();

    aes_cipher_core #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Key store: combinational lookup of the selected key schedule
    assign bus.rk = (bus.rk_idx <= 4'd10) ? rk_tab[key_sel][bus.rk_idx] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used for latency and accept-spacing measurements
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map
    task automatic buildSbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            r1 = {inv[6:0], inv[7]};
            r2 = {r1[6:0], r1[7]};
            r3 = {r2[6:0], r2[7]};
            r4 = {r3[6:0], r3[7]};
            tb_sbox[b] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    task automatic expandKey(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one block, push its expected ciphertext, wait for the accepting
    // edge, then scramble plaintext so any late sampling would corrupt the result
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] ct,
                                 input bit hold, output int acc_edge);
        bit got;
        got      = 1'b0;
        acc_edge = -1;
        bus.plaintext = pt;
        bus.in_valid  = 1'b1;
        exp_q.push_back(ct);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout got=no_accept expected=accept");
            bus.in_valid = 1'b0;
            exp_q.delete();
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        acc_edge = cycle;
        if (!hold) bus.in_valid = 1'b0;
        bus.plaintext = ~pt;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout got=%0d_pending expected=0_pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Accept monitor: remembers the edge on which each block is taken
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            accepts++;
            last_acc_edge = cycle + 1;
        end
    end

    // Scoreboard monitor: latency on out_valid rise, idle ciphertext zero, result compare
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov)
                checkOutput("latency_edge", 128'(cycle), 128'(last_acc_edge + 10));
            if (!bus.out_valid)
                checkOutput("ciphertext_idle_zero", bus.ciphertext, '0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output got=%h expected=none", bus.ciphertext);
                end else begin
                    checkOutput("ciphertext", bus.ciphertext, exp_q.pop_front());
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_edge;
        int edges [8];
        int acc_before;
        bit got;
        int order [8];

        checks        = 0;
        failures      = 0;
        accepts       = 0;
        last_acc_edge = 0;
        prev_ov       = 1'b0;
        key_sel       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.plaintext = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;

        kat_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        kat_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        kat_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        kat_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        kat_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        kat_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        kat_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        kat_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        kat_pt[4] = PT_B;
        kat_ct[4] = CT_B;
        order = '{0, 1, 4, 2, 3, 4, 1, 0};

        buildSbox();
        expandKey(0, KEY_B);
        expandKey(1, KEY_C1);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_ciphertext", bus.ciphertext, '0);
        checkOutput("reset_rk_idx", bus.rk_idx, 0);
        checkOutput("reset_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 App. B with round-key index sequence
        $display("[TB] App B vector with rk_idx trace");
        key_sel       = 1'b0;
        bus.plaintext = PT_B;
        bus.in_valid  = 1'b1;
        exp_q.push_back(CT_B);
        @(negedge clk);
        checkOutput("appb_rk_idx_0", bus.rk_idx, 0);
        checkOutput("appb_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.plaintext = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput("appb_rk_idx_round", bus.rk_idx, 128'(k));
            checkOutput("appb_busy", bus.busy, 1);
        end
        @(negedge clk);
        checkOutput("appb_rk_idx_done", bus.rk_idx, 0);
        checkOutput("appb_out_valid_after_e10", bus.out_valid, 1);
        @(posedge clk);
        #1;
        waitDrain();

        // FIPS-197 App. C.1; plaintext is scrambled right after the accept edge
        $display("[TB] App C.1 vector with plaintext change after accept");
        key_sel = 1'b1;
        applyStimulus(PT_C1, CT_C1, 1'b0, acc_edge);
        waitDrain();

        // Back-to-back known-answer blocks with in_valid and out_ready held
        $display("[TB] back-to-back blocks");
        key_sel = 1'b0;
        for (int i = 0; i < 8; i++)
            applyStimulus(kat_pt[order[i]], kat_ct[order[i]], 1'b1, edges[i]);
        bus.in_valid = 1'b0;
        for (int i = 1; i < 8; i++)
            checkOutput("accept_spacing", 128'(edges[i] - edges[i-1]), 128'(12));
        waitDrain();

        // Backpressure: result held, in_ready low, stray in_valid ignored
        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        key_sel       = 1'b1;
        applyStimulus(PT_C1, CT_C1, 1'b0, acc_edge);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("bp_out_valid_seen", got, 1);
        acc_before = accepts;
        for (int i = 0; i < 20; i++) begin
            checkOutput("bp_ciphertext_stable", bus.ciphertext, CT_C1);
            checkOutput("bp_in_ready_low", bus.in_ready, 0);
            @(posedge clk);
            #1;
            if (i == 5) begin
                bus.plaintext = PT_B;
                bus.in_valid  = 1'b1;
            end
            if (i == 6) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        checkOutput("bp_stray_not_accepted", 128'(accepts - acc_before), 0);
        @(posedge clk);
        #1;
        key_sel       = 1'b0;
        bus.plaintext = kat_pt[0];
        bus.in_valid  = 1'b1;
        exp_q.push_back(kat_ct[0]);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_idle_in_ready", bus.in_ready, 1);
        checkOutput("bp_idle_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.plaintext = '0;
        checkOutput("bp_second_accepted", 128'(accepts - acc_before), 1);
        bus.out_ready = 1'b1;
        waitDrain();

        // Reset while round 5 is in progress
        $display("[TB] reset in flight");
        key_sel = 1'b0;
        applyStimulus(PT_B, CT_B, 1'b0, acc_edge);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rk_idx == 4'd5) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rst_reached_round5", got, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_ciphertext", bus.ciphertext, '0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_rk_idx", bus.rk_idx, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(PT_B, CT_B, 1'b0, acc_edge);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
